// File: rtl/icape_pkg.sv
// Shared definitions for the ICAPE2 command sequencer: op codes, register map, state encoding.
`default_nettype none

package icape_pkg;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_REBOOT = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [4:0] REG_CMD    = 5'h04;
    localparam logic [4:0] REG_STAT   = 5'h07;
    localparam logic [4:0] REG_IDCODE = 5'h0c;
    localparam logic [4:0] REG_WBSTAR = 5'h10;

    localparam logic [31:0] CMD_IPROG = 32'h0000000f;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STB  = 3'd1,
        ST_ACK  = 3'd2,
        ST_STB2 = 3'd3,
        ST_ACK2 = 3'd4,
        ST_RESP = 3'd5
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/wbicape_seq.sv
// Wishbone master that sequences READ/WRITE/REBOOT commands onto the ICAPE2 register bus,
// with a per-beat ack timeout so a hung or rebooting slave never blocks the requester.
`default_nettype none

module wbicape_seq
    import icape_pkg::*;
#(
    parameter int TIMEOUT_LG = 10
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    output logic        o_rsp_err,
    output logic [31:0] o_rsp_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    localparam logic [TIMEOUT_LG-1:0] T_LAST = {TIMEOUT_LG{1'b1}};
    // Leave a beat one cycle before saturation so the bus is released exactly 2^LG-1 cycles after stb.
    localparam logic [TIMEOUT_LG-1:0] T_HIT  = {{(TIMEOUT_LG-1){1'b1}}, 1'b0};

    seq_state_t state;
    seq_state_t state_d;

    logic [1:0]            op_q;
    logic                  we_q;
    logic [4:0]            addr_q;
    logic [31:0]           wdata_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_data_q;
    logic [TIMEOUT_LG-1:0] timer;

    logic latch_cmd;
    logic clr_timer;
    logic load_beat2;
    logic cap_rdata;
    logic set_err;
    logic busy;
    logic timeout;

    assign busy    = (state == ST_STB) || (state == ST_ACK) ||
                     (state == ST_STB2) || (state == ST_ACK2);
    assign timeout = (timer == T_HIT);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        latch_cmd  = 1'b0;
        clr_timer  = 1'b0;
        load_beat2 = 1'b0;
        cap_rdata  = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    latch_cmd = 1'b1;
                    if (i_cmd_op == OP_RSVD) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_STB;
                        clr_timer = 1'b1;
                    end
                end
            end
            ST_STB, ST_STB2: begin
                if (timeout) begin
                    state_d = ST_RESP;
                    set_err = 1'b1;
                end else if (!i_wb_stall) begin
                    state_d = (state == ST_STB) ? ST_ACK : ST_ACK2;
                end
            end
            ST_ACK: begin
                if (i_wb_ack) begin
                    if (op_q == OP_REBOOT) begin
                        state_d    = ST_STB2;
                        clr_timer  = 1'b1;
                        load_beat2 = 1'b1;
                    end else begin
                        state_d   = ST_RESP;
                        cap_rdata = (op_q == OP_READ);
                    end
                end else if (timeout) begin
                    state_d = ST_RESP;
                    set_err = 1'b1;
                end
            end
            ST_ACK2: begin
                if (i_wb_ack) begin
                    state_d = ST_RESP;
                end else if (timeout) begin
                    state_d = ST_RESP;
                    set_err = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_q       <= OP_READ;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            timer      <= '0;
        end else begin
            if (latch_cmd) begin
                op_q       <= i_cmd_op;
                rsp_err_q  <= (i_cmd_op == OP_RSVD);
                rsp_data_q <= '0;
                if (i_cmd_op != OP_RSVD) begin
                    we_q    <= (i_cmd_op != OP_READ);
                    addr_q  <= (i_cmd_op == OP_REBOOT) ? REG_WBSTAR : i_cmd_addr;
                    wdata_q <= (i_cmd_op == OP_READ) ? 32'h0 : i_cmd_data;
                end
            end
            if (load_beat2) begin
                we_q    <= 1'b1;
                addr_q  <= REG_CMD;
                wdata_q <= CMD_IPROG;
            end
            if (cap_rdata) begin
                rsp_data_q <= i_wb_data;
            end
            if (set_err) begin
                rsp_err_q  <= 1'b1;
                rsp_data_q <= '0;
            end
            if (clr_timer) begin
                timer <= '0;
            end else if (busy && (timer != T_LAST)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_rsp_valid = (state == ST_RESP);
    assign o_rsp_err   = (state == ST_RESP) && rsp_err_q;
    assign o_rsp_data  = (state == ST_RESP) ? rsp_data_q : 32'h0;
    assign o_wb_cyc    = busy;
    assign o_wb_stb    = (state == ST_STB) || (state == ST_STB2);
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdata_q;
    assign o_wb_sel    = 4'hf;

endmodule

`default_nettype wire

// File: tb/tb_wbicape_seq.sv
// Directed bench for wbicape_seq: command vector table plus reboot, stray-ack and mid-reboot reset sequences.
`default_nettype none

module tb_wbicape_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        wb_cyc, wb_stb, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    wire         wb_stall;
    wire         wb_ack;
    wire  [31:0] wb_rdata;

    // slave model state and configuration
    logic        slv_stall = 1'b0;
    logic        slv_ack = 1'b0;
    logic [31:0] slv_data = 32'd0;
    logic        stray_ack = 1'b0;
    logic [31:0] stray_data = 32'd0;
    int          stall_n = 0;
    int          ack_dly = 0;
    logic        ack_en = 1'b1;
    logic [31:0] ack_data = 32'd0;
    int          phase = 0;
    int          cnt = 0;
    int          nbeats = 0;
    logic [4:0]  lg_addr[8];
    logic [31:0] lg_data[8];
    logic        lg_we[8];
    logic [3:0]  lg_sel[8];

    int checks = 0;
    int failures = 0;

    assign wb_stall = slv_stall;
    assign wb_ack   = slv_ack | stray_ack;
    assign wb_rdata = stray_ack ? stray_data : slv_data;

    always #5 clk = ~clk;

    wbicape_seq #(.TIMEOUT_LG(10)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
    );

    // Slave: stalls stall_n cycles per beat, then acks ack_dly cycles after acceptance.
    always @(negedge clk) begin
        slv_ack = 1'b0;
        if (!wb_cyc) begin
            phase     = 0;
            slv_stall = 1'b0;
        end else begin
            if (phase == 0 && wb_stb) begin
                phase = 1;
                cnt   = stall_n;
            end
            if (phase == 1) begin
                if (cnt > 0) begin
                    slv_stall = 1'b1;
                    cnt--;
                end else begin
                    slv_stall = 1'b0;
                    lg_addr[nbeats % 8] = wb_addr;
                    lg_data[nbeats % 8] = wb_wdata;
                    lg_we[nbeats % 8]   = wb_we;
                    lg_sel[nbeats % 8]  = wb_sel;
                    nbeats++;
                    phase = 2;
                    cnt   = ack_dly;
                end
            end else if (phase == 2 && ack_en) begin
                if (cnt > 0) begin
                    cnt--;
                end else begin
                    slv_ack  = 1'b1;
                    slv_data = ack_data;
                    phase    = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one command at a negedge; lat is counted in cycles after the accepting edge.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output int b0, output int beats, output logic gap,
                           output logic stb1, output logic ready_after);
        logic seen_cyc;
        @(negedge clk);
        b0        = nbeats;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        stb1      = wb_stb & wb_cyc;
        lat       = -1;
        err       = 1'bx;
        rdata     = 32'hxxxxxxxx;
        gap       = 1'b0;
        seen_cyc  = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) begin
                lat   = k;
                err   = rsp_err;
                rdata = rsp_data;
                break;
            end
            if (wb_cyc) seen_cyc = 1'b1;
            else if (seen_cyc) gap = 1'b1;
        end
        beats = nbeats - b0;
        @(negedge clk);
        ready_after = cmd_ready && !rsp_valid;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] data;
        int          stall;
        int          dly;
        logic        ack_en;
        logic [31:0] ack_data;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_beats;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, beats;
        logic err, gap, stb1, rdy, flag;
        logic [31:0] rdata;

        vecs[0] = '{2'd0, 5'h0c, 32'h0,        7, 140, 1'b1, 32'h13636093, 1'b0, 32'h13636093, 1, 150};
        vecs[1] = '{2'd1, 5'h10, 32'h00400000, 0, 0,   1'b1, 32'hdeadbeef, 1'b0, 32'h0,        1, 3};
        vecs[2] = '{2'd0, 5'h07, 32'h0,        2, 5,   1'b1, 32'h5a5aa5a5, 1'b0, 32'h5a5aa5a5, 1, 10};
        vecs[3] = '{2'd0, 5'h0c, 32'h0,        0, 0,   1'b0, 32'h11111111, 1'b1, 32'h0,        1, 1024};
        vecs[4] = '{2'd0, 5'h0c, 32'h0,        0, 0,   1'b1, 32'h13636093, 1'b0, 32'h13636093, 1, 3};
        vecs[5] = '{2'd3, 5'h1f, 32'hffffffff, 0, 0,   1'b1, 32'h22222222, 1'b1, 32'h0,        0, 1};
        vecs[6] = '{2'd1, 5'h04, 32'h12345678, 3, 1,   1'b1, 32'h33333333, 1'b0, 32'h0,        1, 7};

        // reset state while held in reset
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_bus", {28'd0, wb_cyc, wb_stb, wb_we, rsp_valid}, 32'd0);
        chk("rst_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_sel", {28'd0, wb_sel}, 32'hf);
        chk("rst_rsp", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            stall_n  = vecs[i].stall;
            ack_dly  = vecs[i].dly;
            ack_en   = vecs[i].ack_en;
            ack_data = vecs[i].ack_data;
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, lat, err, rdata, b0, beats, gap, stb1, rdy);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_beats", i), beats, vecs[i].exp_beats);
            chk($sformatf("v%0d_stb_n1", i), {31'd0, stb1}, {31'd0, vecs[i].op != 2'd3});
            chk($sformatf("v%0d_ready_after", i), {31'd0, rdy}, 32'd1);
            if (vecs[i].exp_beats > 0) begin
                chk($sformatf("v%0d_addr", i), {27'd0, lg_addr[b0 % 8]}, {27'd0, vecs[i].addr});
                chk($sformatf("v%0d_we", i), {31'd0, lg_we[b0 % 8]}, {31'd0, vecs[i].op == 2'd1});
                chk($sformatf("v%0d_sel", i), {28'd0, lg_sel[b0 % 8]}, 32'hf);
                if (vecs[i].op == 2'd1)
                    chk($sformatf("v%0d_wdata", i), lg_data[b0 % 8], vecs[i].data);
            end
        end

        // REBOOT: WBSTAR then CMD=IPROG under one continuous cycle
        stall_n = 0; ack_dly = 0; ack_en = 1'b1; ack_data = 32'h44444444;
        run_cmd(2'd2, 5'h00, 32'h00800000, lat, err, rdata, b0, beats, gap, stb1, rdy);
        chk("rb_lat", lat, 5);
        chk("rb_err", {31'd0, err}, 32'd0);
        chk("rb_rdata", rdata, 32'd0);
        chk("rb_beats", beats, 2);
        chk("rb_cyc_gap", {31'd0, gap}, 32'd0);
        chk("rb_b1_addr", {27'd0, lg_addr[b0 % 8]}, 32'h10);
        chk("rb_b1_data", lg_data[b0 % 8], 32'h00800000);
        chk("rb_b1_we", {31'd0, lg_we[b0 % 8]}, 32'd1);
        chk("rb_b2_addr", {27'd0, lg_addr[(b0 + 1) % 8]}, 32'h04);
        chk("rb_b2_data", lg_data[(b0 + 1) % 8], 32'h0000000f);
        chk("rb_b2_we", {31'd0, lg_we[(b0 + 1) % 8]}, 32'd1);
        chk("rb_ready_after", {31'd0, rdy}, 32'd1);

        // stray ack while idle
        flag = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1; stray_data = 32'hcafef00d;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) stray_ack = 1'b0;
            if (rsp_valid || !cmd_ready || wb_cyc) flag = 1'b1;
        end
        chk("stray_ack_ignored", {31'd0, flag}, 32'd0);

        // async reset while REBOOT waits in ACK
        stall_n = 0; ack_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'h00800000;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_cyc_before_rst", {30'd0, wb_cyc, wb_stb}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_drop", {29'd0, wb_cyc, wb_stb, rsp_valid}, 32'd0);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc) flag = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid || wb_cyc) flag = 1'b1;
        chk("mid_rst_no_rsp", {31'd0, flag}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // bus usable again after the reset
        stall_n = 1; ack_dly = 2; ack_en = 1'b1; ack_data = 32'h0badf00d;
        run_cmd(2'd0, 5'h07, 32'h0, lat, err, rdata, b0, beats, gap, stb1, rdy);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_rdata", rdata, 32'h0badf00d);
        chk("post_rst_err", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
